// File: rtl/pad_test_pkg.sv
// Shared types and constants for the pad-ring loopback self-test sequencer.
package pad_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [7:0] FIRST_FAIL_NONE = 8'hFF;

  // Number of patterns in one run: walking one, walking zero, all-0, all-1.
  function automatic int unsigned npat(input int unsigned n_pads);
    return 2 * n_pads + 2;
  endfunction

endpackage

// File: rtl/pad_pattern_gen.sv
// Combinational map from pattern index to the N_PADS-bit loopback test pattern.
module pad_pattern_gen #(
  parameter int unsigned N_PADS = 8
) (
  input  logic [7:0]        i_idx,
  output logic [N_PADS-1:0] o_pattern
);

  localparam logic [7:0] N_IDX  = 8'(N_PADS);
  localparam logic [7:0] N2_IDX = 8'(2 * N_PADS);

  logic [7:0] w_zero_bit;

  assign w_zero_bit = i_idx - N_IDX;

  always_comb begin
    o_pattern = '0;
    if (i_idx < N_IDX) begin
      o_pattern = N_PADS'(1) << i_idx;
    end else if (i_idx < N2_IDX) begin
      o_pattern = ~(N_PADS'(1) << w_zero_bit);
    end else if (i_idx == N2_IDX) begin
      o_pattern = '0;
    end else begin
      o_pattern = '1;
    end
  end

endmodule

// File: rtl/pad_loopback_seq.sv
// Pad-ring loopback self-test: drives each pattern, waits a settle window, compares pad_in.
// Build option PAD_TEST_STOP_ON_FAIL_EN ends the run at the first mismatching pattern.
module pad_loopback_seq
  import pad_test_pkg::*;
#(
  parameter int unsigned N_PADS     = 8,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic              gclk,
  input  logic              resetn,
  input  logic              start,
  input  logic [N_PADS-1:0] pad_in,
  output logic [N_PADS-1:0] pad_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [7:0]        first_fail
);

  localparam int unsigned NPAT = npat(N_PADS);
  localparam int unsigned SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [7:0]  LAST_IDX = 8'(NPAT - 1);

  if (NPAT > 255 || SETTLE_CYC < 1) begin : g_param_check
    $error("pad_loopback_seq: N_PADS must be <= 126 and SETTLE_CYC >= 1");
  end

  state_e              r_state, w_state_nxt;
  logic [7:0]          r_idx, w_idx_nxt;
  logic [SC_W-1:0]     r_scnt, w_scnt_nxt;
  logic [N_PADS-1:0]   r_pad_out, w_pad_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_pass, w_pass_nxt;
  logic [ERR_W-1:0]    r_err, w_err_nxt, w_err_upd;
  logic [7:0]          r_ff, w_ff_nxt;
  logic [7:0]          w_pat_idx;
  logic [N_PADS-1:0]   w_pattern;
  logic                w_mismatch;

  // Pattern needed on the next edge: index 0 on start, idx+1 when leaving SAMPLE.
  assign w_pat_idx  = (r_state == ST_SAMPLE) ? r_idx + 8'd1 : 8'd0;
  assign w_mismatch = (pad_in != r_pad_out);

  pad_pattern_gen #(.N_PADS(N_PADS)) u_pattern_gen (
    .i_idx     (w_pat_idx),
    .o_pattern (w_pattern)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_scnt_nxt  = r_scnt;
    w_pad_nxt   = r_pad_out;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_ff_nxt    = r_ff;
    w_err_upd   = r_err;
    if (w_mismatch && !(&r_err)) begin
      w_err_upd = r_err + ERR_W'(1);
    end

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_DRIVE;
          w_idx_nxt   = 8'd0;
          w_err_nxt   = '0;
          w_ff_nxt    = FIRST_FAIL_NONE;
          w_pass_nxt  = 1'b0;
          w_pad_nxt   = w_pattern;
        end
      end
      ST_DRIVE: begin
        w_state_nxt = ST_SETTLE;
        w_scnt_nxt  = SC_W'(SETTLE_CYC - 1);
      end
      ST_SETTLE: begin
        if (r_scnt == '0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_scnt_nxt = r_scnt - SC_W'(1);
        end
      end
      ST_SAMPLE: begin
        w_err_nxt = w_err_upd;
        if (w_mismatch && (r_ff == FIRST_FAIL_NONE)) begin
          w_ff_nxt = r_idx;
        end
`ifdef PAD_TEST_STOP_ON_FAIL_EN
        if (w_mismatch || (r_idx == LAST_IDX)) begin
`else
        if (r_idx == LAST_IDX) begin
`endif
          w_state_nxt = ST_DONE;
          w_pass_nxt  = (w_err_upd == '0);
          w_pad_nxt   = '0;
        end else begin
          w_state_nxt = ST_DRIVE;
          w_idx_nxt   = r_idx + 8'd1;
          w_pad_nxt   = w_pattern;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SETTLE) ||
                 (w_state_nxt == ST_SAMPLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge gclk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_idx     <= 8'd0;
      r_scnt    <= '0;
      r_pad_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_ff      <= FIRST_FAIL_NONE;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_scnt    <= w_scnt_nxt;
      r_pad_out <= w_pad_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_err     <= w_err_nxt;
      r_ff      <= w_ff_nxt;
    end
  end

  assign pad_out    = r_pad_out;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err;
  assign first_fail = r_ff;

endmodule

// File: tb/tb_pad_loopback_seq.sv
// Scoreboard bench for pad_loopback_seq: loopback faults are modelled on pad_in,
// expected patterns and run results are queued and checked by an independent monitor.
module tb_pad_loopback_seq;

  localparam int unsigned N    = 8;
  localparam int unsigned NPAT = 18;

  typedef struct {
    logic       pass;
    logic [7:0] err;
    logic [7:0] ff;
    int         lat;
  } res_t;

  logic       gclk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] pad_in;
  logic [7:0] pad_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [7:0] first_fail;
  logic [7:0] ref_idx;
  logic [7:0] ref_pat;

  int         fault_mode = 0;
  int         checks     = 0;
  int         failures   = 0;

  res_t       res_q[$];
  logic [7:0] pat_q[$];

  always #5 gclk = ~gclk;

  // Board wiring: 0 clean, 1 pad_in[3] stuck at 0, 2 pad_in[0]/[1] wired-OR.
  always_comb begin
    pad_in = pad_out;
    case (fault_mode)
      1: pad_in[3] = 1'b0;
      2: begin
        pad_in[0] = pad_out[0] | pad_out[1];
        pad_in[1] = pad_out[0] | pad_out[1];
      end
      default: ;
    endcase
  end

  pad_loopback_seq #(.N_PADS(8), .SETTLE_CYC(4), .ERR_W(8)) dut (
    .gclk       (gclk),
    .resetn     (resetn),
    .start      (start),
    .pad_in     (pad_in),
    .pad_out    (pad_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .first_fail (first_fail)
  );

  pad_pattern_gen #(.N_PADS(8)) u_ref_gen (
    .i_idx     (ref_idx),
    .o_pattern (ref_pat)
  );

  function automatic logic [7:0] exp_pat(input int i);
    logic [7:0] p;
    if (i < N)            p = 8'h01 << i;
    else if (i < 2 * N)   p = 8'hFF ^ (8'h01 << (i - N));
    else if (i == 2 * N)  p = 8'h00;
    else                  p = 8'hFF;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: checks each new driven pattern and each completed run against the queues.
  int         cyc = 0;
  int         t_busy = 0;
  int         busy_cnt = 0;
  logic       prev_busy = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] prev_pad = 8'h00;

  always @(negedge gclk) begin
    res_t r;
    logic [7:0] p;
    cyc++;
    if (busy && !prev_busy) begin
      t_busy   = cyc;
      busy_cnt = 1;
    end else if (busy) begin
      busy_cnt++;
    end
    if (busy && (pad_out != prev_pad)) begin
      if (pat_q.size() == 0) begin
        check("pattern_unexpected", 32'(pad_out), 32'(prev_pad));
      end else begin
        p = pat_q.pop_front();
        check("pattern", 32'(pad_out), 32'(p));
      end
    end
    if (done && !prev_done) begin
      if (res_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected: got done=1 expected no pending run");
      end else begin
        r = res_q.pop_front();
        check("pass", 32'(pass), 32'(r.pass));
        check("err_cnt", 32'(err_cnt), 32'(r.err));
        check("first_fail", 32'(first_fail), 32'(r.ff));
        check("latency", 32'(cyc - t_busy), 32'(r.lat));
        check("busy_cycles", 32'(busy_cnt), 32'(r.lat));
      end
    end
    prev_busy = busy;
    prev_done = done;
    prev_pad  = pad_out;
  end

  task automatic push_run(input int npats, input logic ep, input logic [7:0] ee,
                          input logic [7:0] ef, input int el);
    res_t r;
    for (int i = 0; i < npats; i++) pat_q.push_back(exp_pat(i));
    r.pass = ep;
    r.err  = ee;
    r.ff   = ef;
    r.lat  = el;
    res_q.push_back(r);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge gclk);
      n++;
    end while (!done && n < 1000);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 1000 cycles");
    end
  endtask

  task automatic run(input int mode, input int npats, input logic ep, input logic [7:0] ee,
                     input logic [7:0] ef, input int el);
    fault_mode = mode;
    push_run(npats, ep, ee, ef, el);
    @(negedge gclk);
    start = 1'b1;
    @(negedge gclk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done();
    @(negedge gclk);
    check("patterns_consumed", 32'(pat_q.size()), 32'd0);
  endtask

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    ref_idx = 8'd0;
    for (int i = 0; i < int'(NPAT); i++) begin
      ref_idx = 8'(i);
      #1;
      check("pattern_gen", 32'(ref_pat), 32'(exp_pat(i)));
    end
    repeat (3) @(negedge gclk);
    check("rst_pad_out", 32'(pad_out), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_first_fail", 32'(first_fail), 32'hFF);
    resetn = 1'b1;

    run(0, NPAT, 1'b1, 8'd0, 8'hFF, 108);
    check("done_held", 32'(done), 32'd1);
`ifdef PAD_TEST_STOP_ON_FAIL_EN
    run(1, 4, 1'b0, 8'd1, 8'd3, 24);
    run(2, 1, 1'b0, 8'd1, 8'd0, 6);
`else
    run(1, NPAT, 1'b0, 8'd9, 8'd3, 108);
    run(2, NPAT, 1'b0, 8'd4, 8'd0, 108);
`endif

    // Mid-run reset aborts with no result.
    fault_mode = 0;
    push_run(NPAT, 1'b1, 8'd0, 8'hFF, 108);
    @(negedge gclk);
    start = 1'b1;
    @(negedge gclk);
    start = 1'b0;
    repeat (48) @(negedge gclk);
    resetn = 1'b0;
    #1;
    res_q.delete();
    pat_q.delete();
    @(negedge gclk);
    resetn = 1'b1;
    check("abort_pad_out", 32'(pad_out), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_first_fail", 32'(first_fail), 32'hFF);
    run(0, NPAT, 1'b1, 8'd0, 8'hFF, 108);

    // start held high: ignored while busy, immediate restart from DONE.
    push_run(NPAT, 1'b1, 8'd0, 8'hFF, 108);
    @(negedge gclk);
    start = 1'b1;
    wait_done();
    push_run(NPAT, 1'b1, 8'd0, 8'hFF, 108);
    @(negedge gclk);
    check("restart_done_drop", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done();
    @(negedge gclk);
    check("final_patterns", 32'(pat_q.size()), 32'd0);
    check("final_results", 32'(res_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
